// File: rtl/musa_pkg.sv
// rtl/musa_pkg.sv - shared funct codes, flag indices and issue-unit state encoding
package musa_pkg;

  localparam logic [5:0] FUNC_NOP = 6'b000000;
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_MUL = 6'b011000;
  localparam logic [5:0] FUNC_DIV = 6'b011010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_NOT = 6'b100111;

  // Bit positions inside the 4-bit {overflow,equals,above,zero} flag vector
  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_ABOVE    = 1;
  localparam int FLAG_EQUALS   = 2;
  localparam int FLAG_OVERFLOW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic logic func_is_legal(input logic [5:0] f);
    case (f)
      FUNC_ADD, FUNC_SUB, FUNC_MUL, FUNC_DIV,
      FUNC_AND, FUNC_OR, FUNC_NOT: func_is_legal = 1'b1;
      default:                     func_is_legal = 1'b0;
    endcase
  endfunction

  // mul and div need extra EXEC cycles before the alu result settles
  function automatic logic func_is_muldiv(input logic [5:0] f);
    func_is_muldiv = (f == FUNC_MUL) || (f == FUNC_DIV);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - issue-unit bundle: upstream, alu-facing and writeback signals
interface alu_issue_if #(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 6,
  parameter int IMM_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_op1;
  logic [DATA_W-1:0] in_op2;
  logic [IMM_W-1:0]  in_imm;
  logic              in_use_imm;
  logic              in_sign_ext;
  logic [FUNC_W-1:0] in_func;
  logic [DATA_W-1:0] alu_op1;
  logic [DATA_W-1:0] alu_op2;
  logic [FUNC_W-1:0] alu_func;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [3:0]        out_flags;
  logic              out_illegal;
  logic              busy;

  // Issue unit side
  modport slave (
    input  flush, in_valid, in_op1, in_op2, in_imm, in_use_imm, in_sign_ext, in_func,
    input  alu_result, alu_flags, out_ready,
    output in_ready, alu_op1, alu_op2, alu_func,
    output out_valid, out_result, out_flags, out_illegal, busy
  );

  // Surrounding pipeline side (decode, alu, writeback)
  modport master (
    output flush, in_valid, in_op1, in_op2, in_imm, in_use_imm, in_sign_ext, in_func,
    output alu_result, alu_flags, out_ready,
    input  in_ready, alu_op1, alu_op2, alu_func,
    input  out_valid, out_result, out_flags, out_illegal, busy
  );
endinterface

// File: rtl/alu_issue_imm_ext.sv
// rtl/alu_issue_imm_ext.sv - immediate sign/zero extension to operand width
module alu_issue_imm_ext #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] ext
);

  logic fill;

  assign fill = sign_ext & imm[IMM_W-1];
  assign ext  = {{(DATA_W-IMM_W){fill}}, imm};

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - execute-stage issue/capture unit sequencing operands into the alu
module alu_issue
  import musa_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          FUNC_W      = 6,
  parameter int          IMM_W       = 16,
  parameter int unsigned MULDIV_WAIT = 2
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);

  localparam int WAIT_W = 8;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        flags_q, flags_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] imm_ext;
  logic              accept;
  logic              in_ready;

  alu_issue_imm_ext #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_imm_ext (
    .imm      (bus.in_imm),
    .sign_ext (bus.in_sign_ext),
    .ext      (imm_ext)
  );

  // Next-state logic: handshakes, operand latch, wait countdown and result capture
  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    func_d    = func_q;
    wait_d    = wait_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    in_ready  = 1'b0;
    accept    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = bus.in_valid;
      end
      ST_SETUP: begin
        state_d = ST_EXEC;
        wait_d  = func_is_muldiv(func_q) ? WAIT_W'(MULDIV_WAIT) : '0;
      end
      ST_EXEC: begin
        if (wait_q == '0) begin
          result_d = bus.alu_result;
          flags_d  = bus.alu_flags;
          state_d  = ST_HOLD;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_HOLD: begin
        // Downstream taking the result frees the slot in the same cycle
        in_ready = bus.out_ready;
        if (bus.out_ready) begin
          illegal_d = 1'b0;
          if (bus.in_valid) begin
            accept = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over every handshake; an instruction offered now is dropped
    if (bus.flush) begin
      in_ready  = 1'b0;
      accept    = 1'b0;
      state_d   = ST_IDLE;
      illegal_d = 1'b0;
      wait_d    = '0;
    end

    if (accept) begin
      op1_d  = bus.in_op1;
      op2_d  = bus.in_use_imm ? imm_ext : bus.in_op2;
      func_d = bus.in_func;
      if (func_is_legal(bus.in_func)) begin
        state_d   = ST_SETUP;
        illegal_d = 1'b0;
      end else begin
        state_d   = ST_HOLD;
        illegal_d = 1'b1;
        result_d  = '0;
        flags_d   = '0;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op1_q     <= '0;
      op2_q     <= '0;
      func_q    <= FUNC_NOP;
      wait_q    <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      func_q    <= func_d;
      wait_q    <= wait_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  // The alu only sees the real funct in EXEC; SETUP forces NOP so every op has a func edge
  assign bus.alu_op1     = op1_q;
  assign bus.alu_op2     = op2_q;
  assign bus.alu_func    = (state_q == ST_EXEC) ? func_q : FUNC_NOP;
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == ST_HOLD);
  assign bus.out_result  = result_q;
  assign bus.out_flags   = flags_q;
  assign bus.out_illegal = illegal_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
